// File: rtl/wm_billing_pkg.sv
// Shared types and constants for the washing-machine billing controller.
// Holds the FSM state encoding, the BCD digit type and the all-nines saturation helper.
package wm_billing_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSelect  = 3'd1,
        StCharged = 3'd2,
        StFine    = 3'd3,
        StDone    = 3'd4,
        StHandoff = 3'd5
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam int unsigned MaxDigits = 8;

    // Largest representable magnitude for a given digit count; slice the low 4*digits bits.
    function automatic logic [4*MaxDigits-1:0] bcd_all_nines(input int unsigned digits);
        logic [4*MaxDigits-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MaxDigits; i++) begin
            if (i < digits) v[4*i +: 4] = 4'h9;
        end
        return v;
    endfunction

endpackage

// File: rtl/bcd_addsub.sv
// Combinational sign-magnitude BCD subtract: y = a - x, x taken as a positive magnitude.
// mag is the raw digit result; sat flags a carry out of the top digit.
module bcd_addsub
    import wm_billing_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic                  a_neg,
    input  logic [4*DIGITS-1:0]   a_mag,
    input  logic [4*DIGITS-1:0]   x,
    output logic                  y_neg,
    output logic [4*DIGITS-1:0]   y_mag,
    output logic                  sat
);

    localparam int unsigned W = 4*DIGITS;

    function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] r;
        logic [4:0] t;
        bcd_digit_t da, db;
        logic c;
        r = '0;
        c = 1'b0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            da = a[4*d +: 4];
            db = b[4*d +: 4];
            t  = {1'b0, da} + {1'b0, db} + {4'b0, c};
            c  = (t > 5'd9);
            if (c) t = t - 5'd10;
            r[4*d +: 4] = t[3:0];
        end
        r[W] = c;
        return r;
    endfunction

    // Requires a >= b, so no borrow leaves the top digit.
    function automatic logic [W-1:0] bcd_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [4:0] t;
        bcd_digit_t da, db;
        logic c;
        r = '0;
        c = 1'b0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            da = a[4*d +: 4];
            db = b[4*d +: 4];
            t  = {1'b0, da} - {1'b0, db} - {4'b0, c};
            c  = t[4];
            if (c) t = t + 5'd10;
            r[4*d +: 4] = t[3:0];
        end
        return r;
    endfunction

    logic [W:0] sum;

    assign sum = bcd_add(a_mag, x);

    always_comb begin
        y_neg = 1'b0;
        y_mag = '0;
        sat   = 1'b0;
        if (a_neg) begin
            y_neg = 1'b1;
            y_mag = sum[W-1:0];
            sat   = sum[W];
        end else if (a_mag >= x) begin
            y_mag = bcd_sub(a_mag, x);
        end else begin
            y_neg = 1'b1;
            y_mag = bcd_sub(x, a_mag);
        end
    end

endmodule

// File: rtl/wm_billing_ctrl.sv
// Billing controller: timed price confirmation, idle fines, sign-magnitude BCD balance,
// and a valid/ack handoff to the wash sequencer.
module wm_billing_ctrl
    import wm_billing_pkg::*;
#(
    parameter int unsigned DIGITS    = 3,
    parameter int unsigned MODES     = 4,
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned TIMEOUT_S = 8,
    parameter int unsigned FINE_MAX  = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [$clog2(MODES)-1:0]      mode,
    input  logic [MODES*4*DIGITS-1:0]     price_tbl,
    input  logic [4*DIGITS-1:0]           fine,
    input  logic [4*DIGITS-1:0]           bal_in,
    input  logic                          load_bal,
    input  logic                          confirm,
    input  logic                          collect,
    input  logic                          next_ack,
    output logic [4*DIGITS-1:0]           disp_val,
    output logic                          disp_neg,
    output logic [4*DIGITS-1:0]           bal_out,
    output logic                          bal_neg,
    output logic [TIMEOUT_S-1:0]          wt_bar,
    output logic [2:0]                    st_o,
    output logic                          buzz_en,
    output logic                          next,
    output logic [3:0]                    fine_cnt
);

    localparam int unsigned W     = 4*DIGITS;
    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [3:0] CdInit  = 4'(TIMEOUT_S);
    localparam logic [3:0] FineMax = 4'(FINE_MAX);
    localparam logic [4*MaxDigits-1:0] NinesFull = bcd_all_nines(DIGITS);
    localparam logic [W-1:0] Nines = NinesFull[W-1:0];

    state_e           state_q, state_d;
    logic [W-1:0]     bal_q, bal_d;
    logic             bal_neg_q, bal_neg_d;
    logic [3:0]       cd_q, cd_d;
    logic             phase_q, phase_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [3:0]       fine_cnt_q, fine_cnt_d;
    logic             fine_pend_q, fine_pend_d;

    logic             tick;
    logic [W-1:0]     price_sel;
    logic [W-1:0]     sub_x;
    logic             sub_neg;
    logic [W-1:0]     sub_mag;
    logic             sub_sat;
    logic [W-1:0]     new_mag;
    logic             show_price;

    assign tick      = (tick_q == TickLast);
    assign price_sel = price_tbl[int'(mode)*W +: W];
    // In FINE the fine is deducted unless a confirm takes the cycle.
    assign sub_x     = (state_q == StFine && !confirm) ? fine : price_sel;
    assign new_mag   = sub_sat ? Nines : sub_mag;

    bcd_addsub #(
        .DIGITS (DIGITS)
    ) u_addsub (
        .a_neg (bal_neg_q),
        .a_mag (bal_q),
        .x     (sub_x),
        .y_neg (sub_neg),
        .y_mag (sub_mag),
        .sat   (sub_sat)
    );

    always_comb begin
        state_d     = state_q;
        bal_d       = bal_q;
        bal_neg_d   = bal_neg_q;
        cd_d        = cd_q;
        phase_d     = phase_q;
        tick_d      = tick_q;
        fine_cnt_d  = fine_cnt_q;
        fine_pend_d = 1'b0;
        if (state_q == StIdle) begin
            if (load_bal) begin
                bal_d     = bal_in;
                bal_neg_d = 1'b0;
            end
            if (en) begin
                state_d    = StSelect;
                cd_d       = CdInit;
                phase_d    = 1'b0;
                tick_d     = '0;
                fine_cnt_d = '0;
            end
        end else if (!en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StSelect: begin
                    tick_d = tick ? '0 : tick_q + 1'b1;
                    if (confirm) begin
                        bal_d     = new_mag;
                        bal_neg_d = sub_neg;
                        state_d   = StCharged;
                    end else if (cd_q == 4'd0) begin
                        state_d     = StFine;
                        fine_pend_d = 1'b1;
                    end else if (tick) begin
                        cd_d    = cd_q - 4'd1;
                        phase_d = ~phase_q;
                    end
                end
                StFine: begin
                    tick_d = tick ? '0 : tick_q + 1'b1;
                    if (confirm) begin
                        bal_d     = new_mag;
                        bal_neg_d = sub_neg;
                        state_d   = StCharged;
                    end else if ((fine_pend_q || tick) && fine_cnt_q < FineMax) begin
                        bal_d      = new_mag;
                        bal_neg_d  = sub_neg;
                        fine_cnt_d = fine_cnt_q + 4'd1;
                    end
                end
                StCharged: if (collect) state_d = StDone;
                StDone:    state_d = StHandoff;
                StHandoff: if (next_ack) state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bal_q       <= '0;
            bal_neg_q   <= 1'b0;
            cd_q        <= CdInit;
            phase_q     <= 1'b0;
            tick_q      <= '0;
            fine_cnt_q  <= '0;
            fine_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bal_q       <= bal_d;
            bal_neg_q   <= bal_neg_d;
            cd_q        <= cd_d;
            phase_q     <= phase_d;
            tick_q      <= tick_d;
            fine_cnt_q  <= fine_cnt_d;
            fine_pend_q <= fine_pend_d;
        end
    end

    always_comb begin
        wt_bar = '0;
        for (int unsigned i = 0; i < TIMEOUT_S; i++) begin
            wt_bar[i] = (i < 32'(cd_q));
        end
    end

    assign show_price = (state_q == StSelect) && phase_q;
    assign disp_val   = show_price ? price_sel : bal_q;
    assign disp_neg   = show_price ? 1'b0 : bal_neg_q;
    assign bal_out    = bal_q;
    assign bal_neg    = bal_neg_q;
    assign st_o       = state_q;
    assign buzz_en    = (state_q == StSelect) || (state_q == StFine);
    assign next       = (state_q == StHandoff);
    assign fine_cnt   = fine_cnt_q;

endmodule
